muldiv_unit_p: RTL and testbench
================================

Name: muldiv_unit_p

Overview:
- Parametrised HI/LO multiply-divide unit for the EX stage.
- Generalises the fixed 32-bit mul/div block with these additions:
  - parameterised operand width and per-class latency;
  - multiply-accumulate/subtract modes;
  - a one-cycle done pulse;
  - defined divide-by-zero and collision rules.
- The pipeline stalls on busy. MFHI/MFLO read HI/LO directly; MTHI/MTLO write through the hilo write port.

Parameters:
- WIDTH, 32: operand width. HI, LO and each operand are WIDTH bits; the product is 2*WIDTH bits.
- MUL_LAT, 5: busy cycles for the multiply class (MULT, MULTU, MADD, MADDU, MSUB, MSUBU). Must be ≥1.
- DIV_LAT, 10: busy cycles for DIV and DIVU. Must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch operation op with rs/rt, sampled at the rising edge.
- op  in  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- rs  in  WIDTH  operand A, and the data source for MTHI/MTLO.
- rt  in  WIDTH  operand B.
- hilo_we  in  1  direct HI/LO write.
- hilo_sel  in  1  0 writes HI, 1 writes LO.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse on the cycle the result commits.

Behaviour:
- Reset:
  - HI=0, LO=0, busy=0, done=0; counter and state go to IDLE.
  - Reset mid-operation aborts the operation; no commit occurs.
- States:
  - IDLE:
    - start=1 and hilo_we=0 → RUN.
    - Operands, op and the old {HI,LO} are latched at the start edge.
    - The counter loads MUL_LAT-1 or DIV_LAT-1 according to op class.
  - RUN:
    - busy=1; the counter decrements each cycle.
    - At the edge where counter==0: commit the result to HI/LO, set done=1 for the next cycle, return to IDLE.
- Latency:
  - If start is sampled at edge E, busy is high for exactly LAT cycles.
  - HI/LO carry the new value from edge E+LAT onward. done is high in the cycle following edge E+LAT.
- Arithmetic (HI:LO denotes the 2*WIDTH concatenation):
  - MULT/MULTU: HI:LO = signed/unsigned rs*rt.
  - MADD/MADDU: HI:LO = old HI:LO + product, modulo 2^(2*WIDTH).
  - MSUB/MSUBU: HI:LO = old HI:LO − product, modulo 2^(2*WIDTH).
  - DIV: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - The signed most-negative / −1 case gives LO=most-negative, HI=0.
- Divide by zero: the unit runs the full DIV_LAT, HI and LO are left unchanged, and done still pulses.
- Collisions and priorities:
  - hilo_we while idle: the selected register takes rs at the next edge; there is no busy and no done.
  - hilo_we and start in the same cycle: the write wins and the start is dropped.
  - start while busy: ignored.
  - hilo_we while busy: ignored. The pipeline must not issue these; the unit simply discards them.
- Operands are captured at start; rs/rt may change freely during RUN.

Optional Feature:
- Macro: MULDIV_CANCEL_EN.
- With the macro defined:
  - An extra input port cancel (1 bit) is present, used for exception/interrupt flush.
  - cancel=1 in RUN: return to IDLE at the next edge. HI/LO are unchanged, done=0, busy=0 from that edge.
  - cancel=1 in the start cycle: the start is suppressed.
  - cancel has no effect on hilo_we.
- Without the macro: the port is absent and every operation always commits.

Test Plan:
- Reset, then MULT with rs=0xFFFFFFFD, rt=5 → busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1, one-cycle done.
- DIV with rs=0xFFFFFFF9 (−7), rt=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU with rs=7, rt=2 → LO=3, HI=1.
- MTHI 0x1, MTLO 0x0, then MADDU with rs=0xFFFFFFFF, rt=2 → HI=0x2, LO=0xFFFFFFFE. Then MSUBU with the same operands → HI=0x1, LO=0x0.
- Preset HI=0xAA, LO=0xBB, then DIVU with rt=0 → busy for 10 cycles, done pulses, HI/LO stay 0xAA/0xBB.
- Collision cases:
  - start a second MULT during busy → ignored, and the first result is correct.
  - start together with hilo_we=1, sel=1, rs=0x55 → LO=0x55, busy stays 0.
  - reset asserted in the third cycle of a DIV → HI=LO=0, busy=0, no done.
- With MULDIV_CANCEL_EN: cancel in the 2nd busy cycle of MULT → HI/LO unchanged, no done. Rerun with WIDTH=16 and MUL_LAT=1, MULTU with 0xFFFF*0xFFFF → HI=0xFFFE, LO=0x0001 after 1 cycle.

Source files
------------

// File: rtl/muldiv_unit_p.sv
// muldiv_unit_p: parametrised HI/LO multiply/divide unit with MADD/MSUB, done pulse and div-by-zero hold.
// Optional flush input `cancel` is present when MULDIV_CANCEL_EN is defined.
module muldiv_unit_p #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MULDIV_CANCEL_EN
    input  logic             cancel,
`endif
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);
    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic             cancel_w;
`ifdef MULDIV_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif
    // op[0]=0 selects the signed variant of every class
    logic               sgn, div_q, neg_a, neg_b;
    logic [2*WIDTH-1:0] ax, bx, prod, mres;
    logic [WIDTH-1:0]   ua, ub, uq, ur, quo, rem;
    assign sgn   = ~op_q[0];
    assign div_q = ~op_q[2] & op_q[1];
    assign ax    = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign bx    = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = ax * bx;
    assign mres  = op_q[2] ? (op_q[1] ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod) : prod;
    assign neg_a = sgn & a_q[WIDTH-1];
    assign neg_b = sgn & b_q[WIDTH-1];
    assign ua    = neg_a ? -a_q : a_q;
    assign ub    = neg_b ? -b_q : b_q;
    assign uq    = ua / ub;
    assign ur    = ua % ub;
    assign quo   = (neg_a ^ neg_b) ? -uq : uq;
    assign rem   = neg_a ? -ur : ur;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (hilo_we) begin
                hi_d = hilo_sel ? hi_q : rs;
                lo_d = hilo_sel ? rs : lo_q;
            end else if (start && !cancel_w) begin
                state_d = RUN;
                cnt_d   = (~op[2] & op[1]) ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
                op_d    = op;
                a_d     = rs;
                b_d     = rt;
            end
        end else if (cancel_w) begin
            state_d = IDLE;
        end else if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (!div_q) {hi_d, lo_d} = mres;
            else if (b_q != '0) {hi_d, lo_d} = {rem, quo};
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = (state_q == RUN);
    assign done = done_q;
endmodule

// File: tb/tb_muldiv_unit_p.sv
// tb_muldiv_unit_p: randomized and directed checks of muldiv_unit_p against a 64-bit arithmetic model.
module tb_muldiv_unit_p;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, hilo_we = 1'b0, hilo_sel = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs = '0, rt = '0, hi, lo;
    logic        busy, done;
    logic        start16 = 1'b0;
    logic [15:0] rs16 = '0, rt16 = '0, hi16, lo16;
    logic        busy16, done16;
    logic [63:0] hl_m;
    int          n_chk = 0, n_pass = 0;
`ifdef MULDIV_CANCEL_EN
    logic        cancel = 1'b0;
`endif
    always #5 clk = ~clk;
    muldiv_unit_p dut (
        .clk(clk), .reset(reset),
`ifdef MULDIV_CANCEL_EN
        .cancel(cancel),
`endif
        .start(start), .op(op), .rs(rs), .rt(rt), .hilo_we(hilo_we), .hilo_sel(hilo_sel),
        .HI(hi), .LO(lo), .busy(busy), .done(done)
    );
    muldiv_unit_p #(.WIDTH(16), .MUL_LAT(1)) dut16 (
        .clk(clk), .reset(reset),
`ifdef MULDIV_CANCEL_EN
        .cancel(1'b0),
`endif
        .start(start16), .op(3'd1), .rs(rs16), .rt(rt16), .hilo_we(1'b0), .hilo_sel(1'b0),
        .HI(hi16), .LO(lo16), .busy(busy16), .done(done16)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] old);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = o[0] ? {32'd0, a} * {32'd0, b} : 64'(sa * sb);
        case (o)
            3'd2: begin
                if (b == 0) return old;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 0) return old;
                return {a % b, a / b};
            end
            3'd4, 3'd5: return old + p;
            3'd6, 3'd7: return old - p;
            default: return p;
        endcase
    endfunction
    // Launch one op; optionally inject a stray start (and hilo_we) on busy cycle inj.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj, input logic we_inj);
        int          lat, nb, nd, dat;
        logic [63:0] exp;
        lat = (o == 3'd2 || o == 3'd3) ? 10 : 5;
        nb = 0; nd = 0; dat = 0;
        exp = model(o, a, b, hl_m);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            nb += int'(busy);
            if (done) begin nd++; dat = k; end
            start = (k == inj);
            hilo_we = (k == inj) && we_inj;
            hilo_sel = 1'($urandom);
            rs = $urandom; rt = $urandom; op = 3'($urandom);
        end
        start = 1'b0; hilo_we = 1'b0;
        hl_m = exp;
        chk("busy_cycles", 64'(nb), 64'(lat));
        chk("done_count", 64'(nd), 64'd1);
        chk("done_cycle", 64'(dat), 64'(lat + 1));
        chk("hilo", {hi, lo}, hl_m);
    endtask
    task automatic mt(input logic sel, input logic [31:0] v, input logic st);
        @(negedge clk);
        hilo_we = 1'b1; hilo_sel = sel; rs = v; start = st; op = 3'($urandom);
        @(negedge clk);
        hilo_we = 1'b0; start = 1'b0;
        if (sel) hl_m[31:0] = v; else hl_m[63:32] = v;
        chk("mt_hilo", {hi, lo}, hl_m);
        chk("mt_busy", 64'(busy), 64'd0);
        chk("mt_done", 64'(done), 64'd0);
    endtask
    function automatic logic [31:0] pick();
        logic [31:0] sp [5] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
    endfunction
    initial begin
        int nd;
        hl_m = '0;
        repeat (3) @(negedge clk);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        run_op(3'd0, 32'hFFFFFFFD, 32'd5, 0, 1'b0);
        chk("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
        chk("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(3'd3, 32'd7, 32'd2, 0, 1'b0);
        chk("divu_const", {hi, lo}, 64'h00000001_00000003);
        mt(1'b0, 32'd1, 1'b0);
        mt(1'b1, 32'd0, 1'b0);
        run_op(3'd5, 32'hFFFFFFFF, 32'd2, 0, 1'b0);
        chk("maddu_const", {hi, lo}, 64'h00000002_FFFFFFFE);
        run_op(3'd7, 32'hFFFFFFFF, 32'd2, 0, 1'b0);
        chk("msubu_const", {hi, lo}, 64'h00000001_00000000);
        mt(1'b0, 32'hAA, 1'b0);
        mt(1'b1, 32'hBB, 1'b0);
        run_op(3'd3, 32'd123, 32'd0, 0, 1'b0);
        chk("div0_const", {hi, lo}, 64'h000000AA_000000BB);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
        chk("div_ovf_const", {hi, lo}, 64'h00000000_80000000);
        run_op(3'd0, 32'd1234, 32'd5678, 2, 1'b0);
        run_op(3'd1, 32'hDEADBEEF, 32'h12345, 4, 1'b1);
        mt(1'b1, 32'h55, 1'b1);
        chk("collide_lo", {32'd0, lo}, 64'h55);
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs = 32'd100; rt = 32'd7;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; hl_m = '0;
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        nd = 0;
        repeat (12) begin @(negedge clk); nd += int'(done); end
        chk("rst_mid_nodone", 64'(nd), 64'd0);
        @(negedge clk);
        start16 = 1'b1; rs16 = 16'hFFFF; rt16 = 16'hFFFF;
        @(negedge clk); start16 = 1'b0;
        chk("w16_busy", 64'(busy16), 64'd1);
        @(negedge clk);
        chk("w16_idle", 64'(busy16), 64'd0);
        chk("w16_done", 64'(done16), 64'd1);
        chk("w16_hilo", {32'd0, hi16, lo16}, 64'hFFFE0001);
`ifdef MULDIV_CANCEL_EN
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs = 32'd77; rt = 32'd99;
        @(negedge clk); start = 1'b0;
        @(negedge clk); cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        nd = 0;
        repeat (8) begin @(negedge clk); nd += int'(done); end
        chk("cancel_nodone", 64'(nd), 64'd0);
        chk("cancel_hilo", {hi, lo}, hl_m);
        start = 1'b1; cancel = 1'b1;
        @(negedge clk); start = 1'b0; cancel = 1'b0;
        chk("cancel_start", 64'(busy), 64'd0);
`endif
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                mt(1'($urandom), $urandom, 1'($urandom));
            end else begin
                logic [2:0] o;
                o = 3'($urandom);
                run_op(o, pick(), pick(), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0,
                       1'($urandom));
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
